// File: rtl/vga_timing_pkg.sv
// Shared 1280x1024@60 timing constants, derived totals and chessboard tile sizes
// for the timing generator and the pixel drawer.
package vga_timing_pkg;

    localparam int VGA_H_ACTIVE = 1280;
    localparam int VGA_H_FP     = 48;
    localparam int VGA_H_SYNC   = 112;
    localparam int VGA_H_BP     = 248;
    localparam int VGA_V_ACTIVE = 1024;
    localparam int VGA_V_FP     = 1;
    localparam int VGA_V_SYNC   = 3;
    localparam int VGA_V_BP     = 38;

    localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    // Chessboard is 8x8 tiles over the visible area (160x128 at the default mode).
    localparam int VGA_TILE_W   = VGA_H_ACTIVE / 8;
    localparam int VGA_TILE_H   = VGA_V_ACTIVE / 8;

    localparam int COORD_W      = 11;
    localparam int MAX_TOTAL    = 2048;

    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } gen_state_e;

    // True when c lies in the inclusive window [first, last].
    function automatic logic in_window(input coord_t c, input int first, input int last);
        return (int'(c) >= first) && (int'(c) <= last);
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle: count enable in, position/visibility/sync/pulses out.
interface vga_timing_gen_if;
    import vga_timing_pkg::*;

    logic   en;
    coord_t x;
    coord_t y;
    logic   valid;
    logic   hsync;
    logic   vsync;
    logic   line_start;
    logic   frame_start;

    modport master (
        input  en,
        output x, y, valid, hsync, vsync, line_start, frame_start
    );

    modport slave (
        output en,
        input  x, y, valid, hsync, vsync, line_start, frame_start
    );

endinterface

// File: rtl/vga_timing_gen.sv
// Raster position counter with visible-area flag, line/frame start pulses and
// sync outputs delayed one clock to line up with a registered colour path.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter bit SYNC_POL = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    vga_timing_gen_if.master vga
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_FIRST = H_ACTIVE + H_FP;
    localparam int HS_LAST  = H_ACTIVE + H_FP + H_SYNC - 1;
    localparam int VS_FIRST = V_ACTIVE + V_FP;
    localparam int VS_LAST  = V_ACTIVE + V_FP + V_SYNC - 1;

    generate
        if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_bad_totals
            $fatal(1, "vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 2048");
        end
        if (H_ACTIVE < 1 || V_ACTIVE < 1 || H_SYNC < 1 || V_SYNC < 1) begin : g_bad_widths
            $fatal(1, "vga_timing_gen: active area and sync widths must be non-zero");
        end
    endgenerate

    gen_state_e state_q, state_d;
    coord_t     x_q, x_d;
    coord_t     y_q, y_d;
    logic       valid_q, valid_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       line_start_q, line_start_d;
    logic       frame_start_q, frame_start_d;
    logic       en;
    logic       h_wrap;
    logic       v_wrap;

    assign en     = vga.en;
    assign h_wrap = (int'(x_q) == H_TOTAL - 1);
    assign v_wrap = (int'(y_q) == V_TOTAL - 1);

    always_comb begin
        state_d       = state_q;
        x_d           = x_q;
        y_d           = y_q;
        valid_d       = valid_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;

        if (en) begin
            // Sync reflects the position being presented now, so it lands one clock late.
            hsync_d = (state_q == ST_RUN && in_window(x_q, HS_FIRST, HS_LAST)) ? SYNC_POL : ~SYNC_POL;
            vsync_d = (state_q == ST_RUN && in_window(y_q, VS_FIRST, VS_LAST)) ? SYNC_POL : ~SYNC_POL;

            case (state_q)
                ST_IDLE: begin
                    // First enabled edge after reset presents (0,0) rather than advancing past it.
                    state_d = ST_RUN;
                    x_d     = '0;
                    y_d     = '0;
                end
                ST_RUN: begin
                    if (h_wrap) begin
                        x_d = '0;
                        y_d = v_wrap ? '0 : y_q + 1'b1;
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase

            valid_d       = (int'(x_d) < H_ACTIVE) && (int'(y_d) < V_ACTIVE);
            line_start_d  = (x_d == '0);
            frame_start_d = (x_d == '0) && (y_d == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            x_q           <= '0;
            y_q           <= '0;
            valid_q       <= 1'b0;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            valid_q       <= valid_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vga.x           = x_q;
    assign vga.y           = y_q;
    assign vga.valid       = valid_q;
    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.line_start  = line_start_q;
    assign vga.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a reduced raster: vector table, randomized enable
// against a position-index model, and trace/freeze/async-reset sequences.
module tb_vga_timing_gen;
    import vga_timing_pkg::*;

    localparam int HA = 16, HFP = 4, HS = 6, HBP = 8;
    localparam int VA = 10, VFP = 1, VS = 3, VBP = 4;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int FRAME = HT * VT;
    localparam bit POL = 1'b1;

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic        valid;
        logic        hs;
        logic        vs;
        logic        ls;
        logic        fs;
    } obs_t;

    typedef struct packed {
        logic en;
        obs_t exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int passes = 0;
    longint k = 0;
    bit last_en = 1'b0;

    vga_timing_gen_if vif ();

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .SYNC_POL(POL)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .vga  (vif.master)
    );

    always #5 clk = ~clk;

    initial begin
        #(10 * 200000);
        $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
        $fatal(1, "watchdog");
    end

    function automatic obs_t mk(int x, int y, bit v, bit ls, bit fs);
        obs_t o;
        o.x = 11'(x); o.y = 11'(y); o.valid = v;
        o.hs = ~POL; o.vs = ~POL; o.ls = ls; o.fs = fs;
        return o;
    endfunction

    // Outputs after kk enabled edges since reset; le = the last edge had en=1.
    function automatic obs_t model(longint kk, bit le);
        obs_t o;
        longint p, q;
        o = mk(0, 0, 1'b0, 1'b0, 1'b0);
        if (kk == 0) return o;
        p = (kk - 1) % FRAME;
        o.x = 11'(p % HT);
        o.y = 11'(p / HT);
        o.valid = (p % HT < HA) && (p / HT < VA);
        o.ls = le && (p % HT == 0);
        o.fs = le && (p == 0);
        if (kk >= 2) begin
            q = (kk - 2) % FRAME;
            o.hs = (q % HT >= HA + HFP && q % HT < HA + HFP + HS) ? POL : ~POL;
            o.vs = (q / HT >= VA + VFP && q / HT < VA + VFP + VS) ? POL : ~POL;
        end
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.x = vif.x; o.y = vif.y; o.valid = vif.valid;
        o.hs = vif.hsync; o.vs = vif.vsync;
        o.ls = vif.line_start; o.fs = vif.frame_start;
        return o;
    endfunction

    task automatic check(input string name, input obs_t exp);
        obs_t act;
        act = sample();
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got x=%0d y=%0d valid=%b hs=%b vs=%b ls=%b fs=%b, expected x=%0d y=%0d valid=%b hs=%b vs=%b ls=%b fs=%b",
                      name, act.x, act.y, act.valid, act.hs, act.vs, act.ls, act.fs,
                      exp.x, exp.y, exp.valid, exp.hs, exp.vs, exp.ls, exp.fs);
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic step();
        bit en_now;
        en_now = vif.en;
        @(posedge clk);
        if (rst_n) begin
            if (en_now) k++;
            last_en = en_now;
        end
        #1;
    endtask

    task automatic reset_and_release();
        rst_n = 1'b0; k = 0; last_en = 1'b0;
        vif.en = 1'b1;
        step(); step();
        check("reset_again", model(0, 1'b0));
        #2 rst_n = 1'b1;
    endtask

    task automatic run_to(input int tx, input int ty, input string name);
        for (int i = 0; i < 2 * FRAME && !(int'(vif.x) == tx && int'(vif.y) == ty); i++) step();
        check_int({name, "_x"}, int'(vif.x), tx);
        check_int({name, "_y"}, int'(vif.y), ty);
    endtask

    vec_t vecs[6];
    obs_t tr[$];
    int fs_idx[$];
    int ls_idx[$];

    initial begin
        int cnt, th, tv, run;

        vif.en = 1'b0;
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("reset_hold", model(0, 1'b0));
        end

        vecs[0] = '{en: 1'b1, exp: mk(0, 0, 1'b1, 1'b1, 1'b1)};
        vecs[1] = '{en: 1'b1, exp: mk(1, 0, 1'b1, 1'b0, 1'b0)};
        vecs[2] = '{en: 1'b0, exp: mk(1, 0, 1'b1, 1'b0, 1'b0)};
        vecs[3] = '{en: 1'b0, exp: mk(1, 0, 1'b1, 1'b0, 1'b0)};
        vecs[4] = '{en: 1'b1, exp: mk(2, 0, 1'b1, 1'b0, 1'b0)};
        vecs[5] = '{en: 1'b1, exp: mk(3, 0, 1'b1, 1'b0, 1'b0)};
        #2 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            vif.en = vecs[i].en;
            step();
            check($sformatf("vector%0d", i), vecs[i].exp);
        end

        for (int i = 0; i < 3 * FRAME; i++) begin
            vif.en = ($urandom_range(0, 9) < 8);
            step();
            check("random", model(k, last_en));
        end

        // Free-running trace of two frames from a fresh reset.
        reset_and_release();
        vif.en = 1'b1;
        for (int i = 0; i < 2 * FRAME + 10; i++) begin
            step();
            tr.push_back(sample());
        end
        foreach (tr[i]) begin
            if (tr[i].fs) fs_idx.push_back(i);
            if (tr[i].ls) ls_idx.push_back(i);
        end
        check_int("first_fs_index", fs_idx.size() > 0 ? fs_idx[0] : -1, 0);
        check_int("frame_period_1", fs_idx.size() >= 2 ? fs_idx[1] - fs_idx[0] : -1, FRAME);
        check_int("frame_period_2", fs_idx.size() >= 3 ? fs_idx[2] - fs_idx[1] : -1, FRAME);
        cnt = 0;
        for (int i = 0; i < FRAME; i++) if (tr[i].valid) cnt++;
        check_int("valid_per_frame", cnt, HA * VA);
        check_int("line_period", ls_idx.size() >= 2 ? ls_idx[1] - ls_idx[0] : -1, HT);
        cnt = 0;
        foreach (ls_idx[i]) if (ls_idx[i] < FRAME) cnt++;
        check_int("lines_per_frame", cnt, VT);

        th = -1;
        for (int i = 0; i < FRAME && th < 0; i++) if (tr[i].hs == POL) th = i;
        check_int("hsync_first_active", th, HA + HFP + 1);
        run = 0;
        for (int i = (th < 0 ? 0 : th); i < FRAME && tr[i].hs == POL; i++) run++;
        check_int("hsync_width", run, HS);

        tv = -1;
        for (int i = 0; i < FRAME && tv < 0; i++) if (tr[i].vs == POL) tv = i;
        check_int("vsync_first_active", tv, (VA + VFP) * HT + 1);
        run = 0;
        for (int i = (tv < 0 ? 0 : tv); i < FRAME && tr[i].vs == POL; i++) run++;
        check_int("vsync_width", run, VS * HT);

        check_int("frame_end_x", int'(tr[FRAME-1].x), HT - 1);
        check_int("frame_end_y", int'(tr[FRAME-1].y), VT - 1);
        check_int("wrap_x", int'(tr[FRAME].x), 0);
        check_int("wrap_y", int'(tr[FRAME].y), 0);

        // Freeze mid-frame and resume.
        reset_and_release();
        vif.en = 1'b1;
        run_to(5, 3, "freeze_reach");
        vif.en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check("freeze", model(k, last_en));
        end
        check_int("freeze_x", int'(vif.x), 5);
        check_int("freeze_ls", int'(vif.line_start), 0);
        vif.en = 1'b1;
        step();
        check_int("resume_x", int'(vif.x), 6);
        check("resume", model(k, last_en));

        // Asynchronous reset between clock edges.
        run_to(9, 7, "async_reach");
        #2 rst_n = 1'b0;
        k = 0; last_en = 1'b0;
        #1;
        check("async_reset_immediate", model(0, 1'b0));
        step(); step();
        check("async_reset_held", model(0, 1'b0));
        #2 rst_n = 1'b1;
        step();
        check("restart", mk(0, 0, 1'b1, 1'b1, 1'b1));
        step();
        check("restart_next", model(k, last_en));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
